// File: rtl/stage4_decode_queue.sv
// rtl/stage4_decode_queue.sv - decode-to-execute instruction queue
// Circular buffer with flush, stall, push-drop and vsetvl-in-flight tracking.
module stage4_decode_queue #(
  parameter int DEPTH      = 4,
  parameter int ENTRY_W    = 96,
  parameter int VSETVL_BIT = 0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       queue_wen,
  input  logic [ENTRY_W-1:0]         wdata,
  input  logic                       ren,
  input  logic                       stall_queue,
  input  logic                       flush_queue,
  output logic [ENTRY_W-1:0]         rdata,
  output logic                       rvalid,
  output logic                       is_queue_full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       vsetvl_pending,
  output logic                       push_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               push, pop, full, vsetvl_any;

  assign full   = (count_q == FULL_CNT);
  assign rvalid = (count_q != '0);
  // Acceptance is judged on registered fullness only; a same-cycle pop never frees room.
  assign push   = queue_wen && !full && !flush_queue;
  assign pop    = ren && rvalid && !stall_queue && !flush_queue;

  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_queue) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q]   = wdata;
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: rdata is masked while the queue is empty.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  always_comb begin
    vsetvl_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i][VSETVL_BIT]) begin
        vsetvl_any = 1'b1;
      end
    end
  end

  assign rdata          = rvalid ? mem_q[rd_ptr_q] : '0;
  assign is_queue_full  = full;
  assign count          = count_q;
  assign vsetvl_pending = vsetvl_any;
  assign push_drop      = queue_wen && full && !flush_queue;

endmodule

// File: tb/tb_stage4_decode_queue.sv
// tb/tb_stage4_decode_queue.sv - scoreboard bench for stage4_decode_queue
// Directed phases then random traffic, checked against a queue-based model.
module tb_stage4_decode_queue;

  localparam int DEPTH   = 4;
  localparam int ENTRY_W = 96;

  logic               CLK = 1'b0;
  logic               RST;
  logic               queue_wen;
  logic [ENTRY_W-1:0] wdata;
  logic               ren;
  logic               stall_queue;
  logic               flush_queue;
  logic [ENTRY_W-1:0] rdata;
  logic               rvalid;
  logic               is_queue_full;
  logic [2:0]         count;
  logic               vsetvl_pending;
  logic               push_drop;

  int checks = 0;
  int errors = 0;

  logic [ENTRY_W-1:0] model_q [$];

  stage4_decode_queue #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .VSETVL_BIT(0)) dut (
    .CLK(CLK), .RST(RST), .queue_wen(queue_wen), .wdata(wdata), .ren(ren),
    .stall_queue(stall_queue), .flush_queue(flush_queue), .rdata(rdata),
    .rvalid(rvalid), .is_queue_full(is_queue_full), .count(count),
    .vsetvl_pending(vsetvl_pending), .push_drop(push_drop)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares outputs with the model at each negedge, then advances
  // the model with the inputs that will be sampled at the next rising edge.
  initial begin
    @(posedge CLK);
    forever begin
      @(negedge CLK);
      begin
        int  n;
        bit  vs;
        bit  full_m;
        n      = model_q.size();
        full_m = (n == DEPTH);
        vs     = 1'b0;
        foreach (model_q[i]) if (model_q[i][0]) vs = 1'b1;
        chk("count", ENTRY_W'(count), ENTRY_W'(n));
        chk("rvalid", ENTRY_W'(rvalid), ENTRY_W'(n > 0));
        chk("is_queue_full", ENTRY_W'(is_queue_full), ENTRY_W'(full_m));
        chk("vsetvl_pending", ENTRY_W'(vsetvl_pending), ENTRY_W'(vs));
        chk("rdata", rdata, (n > 0) ? model_q[0] : '0);
        if (!RST) begin
          chk("push_drop", ENTRY_W'(push_drop), ENTRY_W'(queue_wen && full_m && !flush_queue));
        end
        if (RST || flush_queue) begin
          model_q.delete();
        end else begin
          if (ren && n > 0 && !stall_queue) begin
            void'(model_q.pop_front());
          end
          if (queue_wen && !full_m) begin
            model_q.push_back(wdata);
          end
        end
      end
    end
  end

  task automatic cyc(input logic w, input logic [ENTRY_W-1:0] d, input logic r,
                     input logic s, input logic f);
    queue_wen   = w;
    wdata       = d;
    ren         = r;
    stall_queue = s;
    flush_queue = f;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [ENTRY_W-1:0] ent(input int tag, input bit vs);
    logic [ENTRY_W-1:0] e;
    e    = {32'h1000_0000 + 32'(tag) * 4, $urandom, $urandom};
    e[0] = vs;
    return e;
  endfunction

  initial begin
    RST = 1'b1;
    queue_wen = 1'b0; wdata = '0; ren = 1'b0; stall_queue = 1'b0; flush_queue = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Fill, overfill, drain
    for (int i = 0; i < 4; i++) cyc(1, ent(i, 0), 0, 0, 0);
    cyc(1, ent(99, 0), 0, 0, 0);
    cyc(1, ent(98, 0), 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);

    // Occupancy 2 streaming across pointer wrap
    cyc(1, ent(10, 0), 0, 0, 0);
    cyc(1, ent(11, 0), 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, ent(20 + i, 0), 1, 0, 0);

    // Stall while pushing, then resume
    for (int i = 0; i < 3; i++) cyc(1, ent(40 + i, 0), 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, 0);

    // vsetvl in flight
    cyc(1, ent(50, 1), 0, 0, 0);
    cyc(1, ent(51, 0), 0, 0, 0);
    cyc(1, ent(52, 0), 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 0);

    // Flush at occupancy 3 with push and pop
    for (int i = 0; i < 3; i++) cyc(1, ent(60 + i, 1), 0, 0, 0);
    cyc(1, ent(63, 0), 1, 0, 1);
    cyc(0, '0, 0, 0, 0);

    // Reset mid-stream at occupancy 3
    for (int i = 0; i < 3; i++) cyc(1, ent(70 + i, 1), 0, 0, 0);
    RST = 1'b1;
    cyc(1, ent(73, 0), 1, 0, 0);
    RST = 1'b0;
    cyc(0, '0, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 9) < 6, ent(i, $urandom_range(0, 3) == 0),
          $urandom_range(0, 1), $urandom_range(0, 6) == 0, $urandom_range(0, 39) == 0);
    end
    RST = 1'b0;
    cyc(0, '0, 0, 0, 0);
    @(negedge CLK);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
